crossbar_arbiter: RTL and testbench

Packet-level arbiter and sequencer for the two-port Aurora crossbar. It accepts transfer requests from input port 0 and input port 1, and grants the crossbar to one packet at a time using round-robin. It drives the crossbar's 2-bit `control_crossbar` select and holds it until the packet's last beat is accepted. It also gates per-port input ready and aborts stalled packets with a watchdog.

---
 rtl/crossbar_pkg.sv | 26 ++
 rtl/crossbar_watchdog.sv | 40 ++++
 rtl/crossbar_arbiter.sv | 138 +++++++++++++
 tb/tb_crossbar_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_pkg.sv
// Shared select codes, FSM state type and destination mapping for the
// two-port Aurora crossbar arbiter.
package crossbar_pkg;

    localparam logic [1:0] CB_IDLE     = 2'b00;
    localparam logic [1:0] CB_P0_TO_P1 = 2'b01;
    localparam logic [1:0] CB_P1_TO_P0 = 2'b10;
    localparam logic [1:0] CB_P1_BCAST = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER_P0 = 2'd1,
        XFER_P1 = 2'd2
    } state_t;

    // Port 1 has a crossbar path only to output 0 or to both outputs;
    // "output 1 only" and "nowhere" are not requests.
    function automatic logic p1_dest_routable(input logic [1:0] dest);
        return dest[0];
    endfunction

    function automatic logic [1:0] p1_select(input logic [1:0] dest);
        return dest[1] ? CB_P1_BCAST : CB_P1_TO_P0;
    endfunction

endpackage

// File: rtl/crossbar_watchdog.sv
// Idle-beat watchdog: counts enabled cycles and flags the cycle in which the
// count reaches TIMEOUT_CYCLES.
module crossbar_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST_CNT = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Expiry is flagged while the count is about to reach the limit, so the
    // abort lands on the edge that would make it equal TIMEOUT_CYCLES.
    assign expired = enable && (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || expired) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/crossbar_arbiter.sv
// Round-robin packet arbiter for the two-port crossbar: grants one packet at a
// time, holds the select until the last beat, gates input ready, aborts stalls.
module crossbar_arbiter
    import crossbar_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_port_0,
    input  logic       req_port_1,
    input  logic [1:0] dest_port_1,
    input  logic       valid_in_port_0,
    input  logic       valid_in_port_1,
    input  logic       last_in_port_0,
    input  logic       last_in_port_1,
    input  logic       ready_out_port_0,
    input  logic       ready_out_port_1,
    output logic       ready_in_port_0,
    output logic       ready_in_port_1,
    output logic [1:0] control_crossbar,
    output logic       busy,
    output logic       timeout_err
);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic       last_served_q, last_served_d;  // 1 = port 1 served last
    logic       timeout_err_q, timeout_err_d;

    logic eff_req_1;
    logic grant_0;
    logic grant_1;
    logic accept;
    logic accept_last;
    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    assign eff_req_1 = req_port_1 && p1_dest_routable(dest_port_1);

    // Tie goes to the port not served last.
    assign grant_0 = (state_q == IDLE) && req_port_0 && (!eff_req_1 || last_served_q);
    assign grant_1 = (state_q == IDLE) && eff_req_1 && (!req_port_0 || !last_served_q);

    always_comb begin
        ready_in_port_0 = 1'b0;
        ready_in_port_1 = 1'b0;
        unique case (state_q)
            XFER_P0: ready_in_port_0 = ready_out_port_1;
            XFER_P1: ready_in_port_1 = (sel_q == CB_P1_BCAST) ? (ready_out_port_0 && ready_out_port_1)
                                                              : ready_out_port_0;
            default: ;
        endcase
    end

    always_comb begin
        accept      = 1'b0;
        accept_last = 1'b0;
        unique case (state_q)
            XFER_P0: begin
                accept      = valid_in_port_0 && ready_in_port_0;
                accept_last = accept && last_in_port_0;
            end
            XFER_P1: begin
                accept      = valid_in_port_1 && ready_in_port_1;
                accept_last = accept && last_in_port_1;
            end
            default: ;
        endcase
    end

    assign wd_clear  = grant_0 || grant_1 || accept;
    assign wd_enable = (state_q != IDLE) && !accept;

    crossbar_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        last_served_d = last_served_q;
        timeout_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_0) begin
                    state_d       = XFER_P0;
                    sel_d         = CB_P0_TO_P1;
                    last_served_d = 1'b0;
                end else if (grant_1) begin
                    state_d       = XFER_P1;
                    sel_d         = p1_select(dest_port_1);
                    last_served_d = 1'b1;
                end
            end
            XFER_P0, XFER_P1: begin
                if (accept_last) begin
                    state_d = IDLE;
                    sel_d   = CB_IDLE;
                end else if (wd_expired) begin
                    state_d       = IDLE;
                    sel_d         = CB_IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = CB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            sel_q         <= CB_IDLE;
            last_served_q <= 1'b1;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            last_served_q <= last_served_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign control_crossbar = sel_q;
    assign busy             = (state_q != IDLE);
    assign timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_crossbar_arbiter.sv
// Scoreboarded bench for crossbar_arbiter: a packet-level reference model
// predicts each cycle's outputs, a negedge monitor compares them.
module tb_crossbar_arbiter;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_port_0 = 1'b0;
    logic       req_port_1 = 1'b0;
    logic [1:0] dest_port_1 = 2'b00;
    logic       valid_in_port_0 = 1'b0;
    logic       valid_in_port_1 = 1'b0;
    logic       last_in_port_0 = 1'b0;
    logic       last_in_port_1 = 1'b0;
    logic       ready_out_port_0 = 1'b0;
    logic       ready_out_port_1 = 1'b0;
    logic       ready_in_port_0;
    logic       ready_in_port_1;
    logic [1:0] control_crossbar;
    logic       busy;
    logic       timeout_err;

    crossbar_arbiter #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_port_0      (req_port_0),
        .req_port_1      (req_port_1),
        .dest_port_1     (dest_port_1),
        .valid_in_port_0 (valid_in_port_0),
        .valid_in_port_1 (valid_in_port_1),
        .last_in_port_0  (last_in_port_0),
        .last_in_port_1  (last_in_port_1),
        .ready_out_port_0(ready_out_port_0),
        .ready_out_port_1(ready_out_port_1),
        .ready_in_port_0 (ready_in_port_0),
        .ready_in_port_1 (ready_in_port_1),
        .control_crossbar(control_crossbar),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] sel;
        logic       busy;
        logic       ri0;
        logic       ri1;
        logic       terr;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;
    int   grants_p0 = 0;
    int   grants_p1 = 0;
    int   aborts    = 0;

    // Reference model: owner of the crossbar (-1 none), broadcast flag,
    // which port wins the next tie, and stalled cycles in the current packet.
    int owner   = -1;
    bit bcast   = 1'b0;
    int pref    = 0;
    int stalled = 0;
    bit err_pend = 1'b0;

    task automatic check(input string name, input int c, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, c, got, want);
        end
    endtask

    // One clock cycle of stimulus: drive inputs after the edge, predict this
    // cycle's outputs, then advance the model to the next edge.
    task automatic cyc(input bit r, input bit r0, input bit r1, input logic [1:0] d,
                       input bit v0, input bit l0, input bit v1, input bit l1,
                       input bit ro0, input bit ro1);
        exp_t e;
        bit   routable;
        bit   acc;
        bit   lst;
        int   g;
        @(posedge clk);
        #1;
        rst = r; req_port_0 = r0; req_port_1 = r1; dest_port_1 = d;
        valid_in_port_0 = v0; last_in_port_0 = l0;
        valid_in_port_1 = v1; last_in_port_1 = l1;
        ready_out_port_0 = ro0; ready_out_port_1 = ro1;
        cycle++;
        e.cyc = cycle;
        if (r) begin
            e.sel = 2'b00; e.busy = 1'b0; e.ri0 = 1'b0; e.ri1 = 1'b0; e.terr = 1'b0;
            exp_q.push_back(e);
            owner = -1; bcast = 1'b0; pref = 0; stalled = 0; err_pend = 1'b0;
            return;
        end
        e.sel  = (owner < 0) ? 2'd0 : (owner == 0) ? 2'd1 : (bcast ? 2'd3 : 2'd2);
        e.busy = (owner >= 0);
        e.ri0  = (owner == 0) && ro1;
        e.ri1  = (owner == 1) && ro0 && (!bcast || ro1);
        e.terr = err_pend;
        exp_q.push_back(e);
        err_pend = 1'b0;
        if (owner < 0) begin
            routable = r1 && (d == 2'b01 || d == 2'b11);
            if (r0 && routable) g = pref;
            else if (r0)        g = 0;
            else if (routable)  g = 1;
            else                g = -1;
            if (g >= 0) begin
                owner   = g;
                bcast   = (g == 1) && (d == 2'b11);
                pref    = 1 - g;
                stalled = 0;
                if (g == 0) grants_p0++; else grants_p1++;
            end
        end else begin
            acc = (owner == 0) ? (v0 && e.ri0) : (v1 && e.ri1);
            lst = (owner == 0) ? l0 : l1;
            if (acc) begin
                stalled = 0;
                if (lst) owner = -1;
            end else begin
                stalled++;
                if (stalled == TO) begin
                    owner    = -1;
                    err_pend = 1'b1;
                    stalled  = 0;
                    aborts++;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("control_crossbar", e.cyc, control_crossbar, e.sel);
            check("busy", e.cyc, busy, e.busy);
            check("ready_in_port_0", e.cyc, ready_in_port_0, e.ri0);
            check("ready_in_port_1", e.cyc, ready_in_port_1, e.ri1);
            check("timeout_err", e.cyc, timeout_err, e.terr);
        end
    end

    initial begin
        bit stall;
        repeat (3) cyc(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

        // Port 0, four beats, outputs always ready.
        cyc(0, 1, 0, 2'b00, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 2'b00, 1, (i == 3), 0, 0, 1, 1);
        cyc(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1);

        // Unroutable port 1 destinations stay idle.
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 2'b00, 1, 1, 1, 1, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 2'b10, 1, 1, 1, 1, 1, 1);

        // Both requesting with two-beat packets: alternating grants.
        for (int i = 0; i < 12; i++) cyc(0, 1, 1, 2'b01, 1, (i % 3 == 2), 1, (i % 3 == 2), 1, 1);
        cyc(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1);

        // Broadcast with output 1 back-pressuring for three cycles.
        cyc(0, 0, 1, 2'b11, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 2'b01, 0, 0, 1, 0, 1, 0);
        cyc(0, 0, 0, 2'b01, 0, 0, 1, 0, 1, 1);
        cyc(0, 0, 0, 2'b01, 0, 0, 1, 1, 1, 1);
        cyc(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1);

        // Watchdog: port 0 granted then silent while port 1 waits.
        cyc(0, 1, 0, 2'b00, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < TO + 4; i++) cyc(0, 0, 1, 2'b01, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 2'b00, 0, 0, 1, 1, 1, 1);
        cyc(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1);

        // Randomized traffic with occasional long stalls and rare resets.
        stall = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 48 == 0) stall = ($urandom_range(0, 4) == 0);
            cyc(($urandom_range(0, 499) == 0),
                $urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                !stall && ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                !stall && ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end
        cyc(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1);
        cyc(1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1);

        // Reset in the middle of a broadcast, then a tie goes to port 0.
        cyc(0, 0, 1, 2'b11, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 2'b11, 0, 0, 0, 0, 1, 1);
        cyc(1, 0, 0, 2'b11, 0, 0, 1, 0, 1, 1);
        cyc(0, 1, 1, 2'b01, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 2'b00, 1, 1, 1, 1, 1, 1);
        repeat (3) cyc(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", cycle, exp_q.size(), 0);
        check("aborts_seen", cycle, (aborts > 0), 1);
        check("both_ports_granted", cycle, (grants_p0 > 0 && grants_p1 > 0), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
